// File: rtl/delay_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : delay_slot_arbiter
// Description : Round-robin arbiter that hands one shared timed hold window to
//               one of N requesters at a time. A grant ends on done[gnt_id],
//               on withdrawal of req[gnt_id], or when the hold counter reaches
//               HOLD-1. Consecutive grants are separated by GUARD_CYC idle
//               cycles.
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous reset, active low
//               req      - level request per requester
//               done     - early release; only done[gnt_id] is looked at
//               gnt      - registered one-hot grant
//               gnt_id   - index of current / last grantee
//               busy     - high while in GRANT or GUARD
//               timeout  - one-cycle pulse after a grant ended by expiry
//               s_out    - state code for debug LEDs
// Revision    : 1.0 - initial release
// ============================================================================
module delay_slot_arbiter #(
    parameter int N         = 4,
    parameter int HOLD      = 2**20,
    parameter int GUARD_CYC = 2,
    parameter int DLY_W     = 21
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         done,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 busy,
    output logic                 timeout,
    output logic [1:0]           s_out
);

    localparam int IDW = $clog2(N);

    localparam logic [IDW:0]       c_n_wide    = (IDW+1)'(N);
    localparam logic [DLY_W-1:0]   c_hold_last = DLY_W'(HOLD - 1);
    localparam logic [DLY_W-1:0]   c_guard_last = DLY_W'(GUARD_CYC - 1);
    localparam logic [IDW-1:0]     c_one       = IDW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_GUARD = 2'b10
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [DLY_W-1:0] r_cnt, w_cnt_nxt;
    logic [IDW-1:0]   r_ptr, w_ptr_nxt;
    logic [N-1:0]     r_gnt, w_gnt_nxt;
    logic [IDW-1:0]   r_gnt_id, w_gnt_id_nxt;
    logic             r_timeout, w_timeout_nxt;

    logic [N-1:0]     w_rot;
    logic [IDW-1:0]   w_off;
    logic [IDW-1:0]   w_win;
    logic             w_any;
    logic             w_release;
    logic             w_expire;

    // (a + b) mod N for operands already below N.
    function automatic logic [IDW-1:0] mod_add(input logic [IDW-1:0] a,
                                               input logic [IDW-1:0] b);
        logic [IDW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= c_n_wide) begin
            s = s - c_n_wide;
        end
        return s[IDW-1:0];
    endfunction

    // Rotate req so that bit 0 corresponds to the pointer position; the
    // lowest set bit of the rotated vector is the offset of the winner.
    always_comb begin
        w_rot = N'({req, req} >> r_ptr);
        w_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDW'(k);
            end
        end
        w_any = |req;
        w_win = mod_add(r_ptr, w_off);
    end

    assign w_release = done[r_gnt_id] | ~req[r_gnt_id];
    assign w_expire  = (r_cnt == c_hold_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_ptr_nxt     = r_ptr;
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_timeout_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt         = ST_GRANT;
                    w_cnt_nxt           = '0;
                    w_gnt_nxt           = '0;
                    w_gnt_nxt[w_win]    = 1'b1;
                    w_gnt_id_nxt        = w_win;
                    w_ptr_nxt           = mod_add(w_win, c_one);
                end
            end

            ST_GRANT: begin
                if (w_release || w_expire) begin
                    w_state_nxt   = ST_GUARD;
                    w_cnt_nxt     = '0;
                    w_gnt_nxt     = '0;
                    // A release on the expiry edge wins: no timeout pulse.
                    w_timeout_nxt = w_expire & ~w_release;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            ST_GUARD: begin
                if (r_cnt == c_guard_last) begin
                    w_cnt_nxt = '0;
                    if (w_any) begin
                        w_state_nxt      = ST_GRANT;
                        w_gnt_nxt        = '0;
                        w_gnt_nxt[w_win] = 1'b1;
                        w_gnt_id_nxt     = w_win;
                        w_ptr_nxt        = mod_add(w_win, c_one);
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                // Unused code 2'b11: fall back to IDLE on the next edge.
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign timeout = r_timeout;
    assign busy    = (r_state != ST_IDLE);
    assign s_out   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_delay_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_delay_slot_arbiter
// Description : Directed bench for delay_slot_arbiter (N=4, HOLD=8,
//               GUARD_CYC=2). Each step drives req/done, queues the outputs
//               expected after the next rising edge and compares them once
//               that edge has passed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_slot_arbiter;

    localparam int N         = 4;
    localparam int HOLD      = 8;
    localparam int GUARD_CYC = 2;
    localparam int DLY_W     = 21;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] done = '0;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         busy;
    logic         timeout;
    logic [1:0]   s_out;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       to;
        logic [1:0] s;
        logic       busy;
    } exp_t;

    exp_t sb[$];

    delay_slot_arbiter #(
        .N         (N),
        .HOLD      (HOLD),
        .GUARD_CYC (GUARD_CYC),
        .DLY_W     (DLY_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout),
        .s_out   (s_out)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input logic [3:0] eg, input logic [1:0] eid,
                            input logic eto, input logic [1:0] es);
        exp_t e;
        e.gnt  = eg;
        e.id   = eid;
        e.to   = eto;
        e.s    = es;
        e.busy = (es != 2'b00);
        sb.push_back(e);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $error("FAIL %s scoreboard: got empty queue want entry", tag);
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (gnt === e.gnt) else begin
            errors++;
            $error("FAIL %s gnt: got %b want %b", tag, gnt, e.gnt);
        end
        checks++;
        assert (gnt_id === e.id) else begin
            errors++;
            $error("FAIL %s gnt_id: got %0d want %0d", tag, gnt_id, e.id);
        end
        checks++;
        assert (timeout === e.to) else begin
            errors++;
            $error("FAIL %s timeout: got %b want %b", tag, timeout, e.to);
        end
        checks++;
        assert (s_out === e.s) else begin
            errors++;
            $error("FAIL %s s_out: got %b want %b", tag, s_out, e.s);
        end
        checks++;
        assert (busy === e.busy) else begin
            errors++;
            $error("FAIL %s busy: got %b want %b", tag, busy, e.busy);
        end
    endtask

    // Drive inputs for the coming edge, queue what must appear after it.
    task automatic step(input string tag, input logic [3:0] r,
                        input logic [3:0] d, input logic [3:0] eg,
                        input logic [1:0] eid, input logic eto,
                        input logic [1:0] es);
        req  = r;
        done = d;
        push_exp(eg, eid, eto, es);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    // Assert reset between edges, check the immediate effect, release it
    // just after the following rising edge.
    task automatic apply_reset(input string tag);
        #3;
        rst = 1'b0;
        #1;
        push_exp(4'b0000, 2'd0, 1'b0, 2'b00);
        compare_out(tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [3:0] oh;
        logic [1:0] g;

        // Reset state
        #1 rst = 1'b0;
        #1;
        push_exp(4'b0000, 2'd0, 1'b0, 2'b00);
        compare_out("reset_state");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Single requester held: full hold, expiry pulse, guard, regrant
        for (int c = 0; c < 8; c++)
            step("hold_grant", 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, 2'b01);
        step("hold_expire", 4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b1, 2'b10);
        step("hold_gap",    4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'b10);
        step("hold_regrant",4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0, 2'b01);
        step("drop_rel",    4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'b10);
        step("drop_gap",    4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'b10);
        step("to_idle",     4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'b00);

        apply_reset("reset_idle");

        // All requesting, each releases with done on its third grant cycle
        for (int k = 0; k < 5; k++) begin
            g  = 2'(k % 4);
            oh = 4'b0001 << g;
            for (int c = 0; c < 3; c++)
                step("rr_grant", 4'b1111, 4'b0000, oh, g, 1'b0, 2'b01);
            step("rr_done", 4'b1111, oh,      4'b0000, g, 1'b0, 2'b10);
            step("rr_gap",  4'b1111, 4'b0000, 4'b0000, g, 1'b0, 2'b10);
        end

        // Requester 2 releases on the very edge its hold expires
        for (int c = 0; c < 8; c++)
            step("exp_grant", 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, 2'b01);
        step("exp_done",  4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b0, 2'b10);
        step("exp_gap",   4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 2'b10);
        step("exp_idle",  4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 2'b00);

        apply_reset("reset_wd");

        // Withdrawal of req[1] mid-grant with req[3] waiting
        step("wd_grant", 4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b0, 2'b01);
        step("wd_grant", 4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b0, 2'b01);
        step("wd_drop",  4'b1000, 4'b0000, 4'b0000, 2'd1, 1'b0, 2'b10);
        step("wd_gap",   4'b1000, 4'b0000, 4'b0000, 2'd1, 1'b0, 2'b10);
        step("wd_next",  4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0, 2'b01);
        step("wd_rel",   4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 2'b10);
        step("wd_gap2",  4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 2'b10);
        step("wd_idle",  4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 2'b00);

        // Asynchronous reset mid-grant; pointer must restart at 0
        step("ar_grant", 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, 2'b01);
        step("ar_grant", 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0, 2'b01);
        req = 4'b0101;
        apply_reset("ar_reset");
        step("ar_first", 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b0, 2'b01);

        // No preemption: req[3] rises while requester 0 holds the grant
        for (int c = 0; c < 3; c++)
            step("pre_hold", 4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b0, 2'b01);
        step("pre_done", 4'b1001, 4'b0001, 4'b0000, 2'd0, 1'b0, 2'b10);
        step("pre_gap",  4'b1001, 4'b0000, 4'b0000, 2'd0, 1'b0, 2'b10);
        step("pre_next", 4'b1001, 4'b0000, 4'b1000, 2'd3, 1'b0, 2'b01);
        step("pre_rel",  4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b0, 2'b10);
        step("pre_gap2", 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 2'b10);
        step("pre_idle", 4'b0000, 4'b0000, 4'b0000, 2'd3, 1'b0, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
